// File: rtl/fabric_cfg_pkg.sv
// Shared constants for the fabric configuration loader: sync word, opcodes,
// header field positions and the sequencer state encoding.
package fabric_cfg_pkg;

   localparam logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1;
   localparam logic [3:0]  OP_WRITE_FRAME = 4'h1;
   localparam logic [3:0]  OP_DESYNC      = 4'hF;

   localparam int HDR_OP_MSB  = 31;
   localparam int HDR_OP_LSB  = 28;
   localparam int HDR_COL_MSB = 15;
   localparam int HDR_COL_LSB = 8;
   localparam int HDR_FRM_MSB = 7;
   localparam int HDR_FRM_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CHK,
      ST_STROBE,
      ST_HOLD
   } cfg_state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Column/frame to one-hot FrameStrobe decode.
// Latency: combinational. Backpressure: none; the parent registers the output.
module frame_strobe_decoder
   import fabric_cfg_pkg::*;
#(
   parameter int NUM_COLUMNS    = 12,
   parameter int FRAMES_PER_COL = 20
) (
   input  logic [HDR_COL_MSB-HDR_COL_LSB:0]         column,
   input  logic [HDR_FRM_MSB-HDR_FRM_LSB:0]         frame,
   input  logic                                     enable,
   output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0]    strobe
);

   int sel;

   always_comb begin
      sel    = int'(column) * FRAMES_PER_COL + int'(frame);
      strobe = '0;
      for (int i = 0; i < NUM_COLUMNS*FRAMES_PER_COL; i++) begin
         strobe[i] = enable && (i == sel);
      end
   end

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream word stream -> FrameData assembly + one-hot FrameStrobe pulse (FRAME_CHECK_EN adds an XOR check word).
// Latency: strobe rises the cycle after the last accepted word; 1+NUM_ROWS(+1) accepts + 2 cycles per frame.
// Backpressure: s_ready is registered, high except during the STROBE and HOLD cycles.
module frame_config_sequencer
   import fabric_cfg_pkg::*;
#(
   parameter int NUM_ROWS       = 10,
   parameter int NUM_COLUMNS    = 12,
   parameter int FRAMES_PER_COL = 20
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic [31:0]                            s_data,
   input  logic                                   s_valid,
   output logic                                   s_ready,
   output logic [32*NUM_ROWS-1:0]                 FrameData,
   output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0]  FrameStrobe,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   err
);

   localparam int              WCW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [WCW-1:0]  LAST_W = WCW'(NUM_ROWS - 1);

   cfg_state_t                       state;
   logic [WCW-1:0]                   wcnt;
   logic [HDR_COL_MSB-HDR_COL_LSB:0] col_q;
   logic [HDR_FRM_MSB-HDR_FRM_LSB:0] frm_q;
`ifdef FRAME_CHECK_EN
   logic [31:0]                      chk_acc;
`endif

   logic                                  acc;
   logic [3:0]                            hdr_op;
   logic [HDR_COL_MSB-HDR_COL_LSB:0]      hdr_col;
   logic [HDR_FRM_MSB-HDR_FRM_LSB:0]      hdr_frm;
   logic                                  hdr_addr_ok;
   logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] strobe_vec;

   assign acc         = s_valid & s_ready;
   assign hdr_op      = s_data[HDR_OP_MSB:HDR_OP_LSB];
   assign hdr_col     = s_data[HDR_COL_MSB:HDR_COL_LSB];
   assign hdr_frm     = s_data[HDR_FRM_MSB:HDR_FRM_LSB];
   assign hdr_addr_ok = (int'(hdr_col) < NUM_COLUMNS) && (int'(hdr_frm) < FRAMES_PER_COL);

   // Decoding from the STROBE state delays the pulse one cycle, so FrameData
   // has already been stable for a full cycle when the column latches it.
   frame_strobe_decoder #(
      .NUM_COLUMNS    (NUM_COLUMNS),
      .FRAMES_PER_COL (FRAMES_PER_COL)
   ) u_dec (
      .column (col_q),
      .frame  (frm_q),
      .enable (state == ST_STROBE),
      .strobe (strobe_vec)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_IDLE;
         s_ready     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         wcnt        <= '0;
         col_q       <= '0;
         frm_q       <= '0;
         FrameData   <= '0;
         FrameStrobe <= '0;
`ifdef FRAME_CHECK_EN
         chk_acc     <= '0;
`endif
      end else begin
         FrameStrobe <= strobe_vec;
         case (state)
            ST_IDLE: begin
               s_ready <= 1'b1;
               if (acc && s_data == SYNC_WORD) begin
                  state <= ST_HDR;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            ST_HDR: begin
               if (acc) begin
                  if (hdr_op == OP_WRITE_FRAME && hdr_addr_ok) begin
                     col_q <= hdr_col;
                     frm_q <= hdr_frm;
                     wcnt  <= '0;
`ifdef FRAME_CHECK_EN
                     chk_acc <= '0;
`endif
                     state <= ST_DATA;
                  end else if (hdr_op == OP_DESYNC) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (acc) begin
                  FrameData[32*wcnt +: 32] <= s_data;
`ifdef FRAME_CHECK_EN
                  chk_acc <= chk_acc ^ s_data;
`endif
                  if (wcnt == LAST_W) begin
`ifdef FRAME_CHECK_EN
                     state   <= ST_CHK;
`else
                     state   <= ST_STROBE;
                     s_ready <= 1'b0;
`endif
                  end else begin
                     wcnt <= wcnt + WCW'(1);
                  end
               end
            end
`ifdef FRAME_CHECK_EN
            ST_CHK: begin
               if (acc) begin
                  if (s_data == chk_acc) begin
                     state   <= ST_STROBE;
                     s_ready <= 1'b0;
                  end else begin
                     // Stay synced: a bad frame is dropped, the next word is a header.
                     err   <= 1'b1;
                     state <= ST_HDR;
                  end
               end
            end
`endif
            ST_STROBE: begin
               state <= ST_HOLD;
            end
            ST_HOLD: begin
               state   <= ST_HDR;
               s_ready <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               s_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Bench for frame_config_sequencer: directed and random word streams checked
// against a word-level model of the bitstream protocol (adapts to FRAME_CHECK_EN).
module tb_frame_config_sequencer;

   localparam int NR  = 2;
   localparam int NC  = 3;
   localparam int FPC = 4;
   localparam int FB  = 32*NR;
   localparam int NS  = NC*FPC;
   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [31:0]   s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [FB-1:0] FrameData;
   logic [NS-1:0] FrameStrobe;
   logic          busy, done, err;

   frame_config_sequencer #(
      .NUM_ROWS       (NR),
      .NUM_COLUMNS    (NC),
      .FRAMES_PER_COL (FPC)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Word-level protocol model: 0 unsynced, 1 header, 2 data, 3 checksum
   int          m_mode = 0;
   logic        m_done = 1'b0;
   logic        m_err  = 1'b0;
   logic [FB-1:0] m_fd = '0;
   int          m_k    = 0;
   int          m_idx  = 0;
   logic [31:0] m_x    = '0;
   int          exp_idx[$];
   logic [FB-1:0] exp_dat[$];
   int          obs_idx[$];
   logic [FB-1:0] obs_dat[$];

   task automatic model_reset();
      m_mode = 0; m_done = 1'b0; m_err = 1'b0; m_fd = '0; m_k = 0; m_x = '0;
      exp_idx.delete(); exp_dat.delete();
      obs_idx.delete(); obs_dat.delete();
   endtask

   task automatic model_word(input logic [31:0] w);
      int op, c, f;
      op = int'(w[31:28]); c = int'(w[15:8]); f = int'(w[7:0]);
      case (m_mode)
         0: if (w == SYNC) begin m_mode = 1; m_done = 1'b0; end
         1: begin
            if (op == 1 && c < NC && f < FPC) begin
               m_idx = c*FPC + f; m_k = 0; m_x = '0; m_mode = 2;
            end else if (op == 15) begin
               m_done = 1'b1; m_mode = 0;
            end else begin
               m_err = 1'b1; m_mode = 0;
            end
         end
         2: begin
            m_fd[32*m_k +: 32] = w;
            m_x = m_x ^ w;
            m_k++;
            if (m_k == NR) begin
`ifdef FRAME_CHECK_EN
               m_mode = 3;
`else
               exp_idx.push_back(m_idx); exp_dat.push_back(m_fd); m_mode = 1;
`endif
            end
         end
         default: begin
            if (w == m_x) begin exp_idx.push_back(m_idx); exp_dat.push_back(m_fd); end
            else m_err = 1'b1;
            m_mode = 1;
         end
      endcase
   endtask

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic put(input logic [31:0] w, input int gap);
      bit   ok = 1'b0;
      logic r;
      s_valid = 1'b0;
      repeat (gap) @(negedge CLK);
      s_valid = 1'b1; s_data = w;
      for (int t = 0; t < 20 && !ok; t++) begin
         r = s_ready;
         @(negedge CLK);
         ok = r;
      end
      s_valid = 1'b0; s_data = $urandom;
      if (!ok) check("accept_timeout", ok, 1);
      else model_word(w);
   endtask

   task automatic settle();
      repeat (6) @(negedge CLK);
   endtask

   task automatic compare_scn(input string tag);
      int n;
      check({tag, "_nstrobes"}, obs_idx.size(), exp_idx.size());
      n = (obs_idx.size() < exp_idx.size()) ? obs_idx.size() : exp_idx.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_idx"}, obs_idx[i], exp_idx[i]);
         check({tag, "_dat"}, obs_dat[i], exp_dat[i]);
      end
      check({tag, "_done"}, done, m_done);
      check({tag, "_err"},  err,  m_err);
      check({tag, "_busy"}, busy, m_mode != 0);
      check({tag, "_fd"},   FrameData, m_fd);
      exp_idx.delete(); exp_dat.delete();
      obs_idx.delete(); obs_dat.delete();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      model_reset();
   endtask

   // Strobe monitor: one-hot, single cycle, second cycle of the ready-low window,
   // FrameData stable the cycle before and after.
   initial begin
      int            lowrun = -100;
      logic [NS-1:0] prev_st = '0;
      logic [FB-1:0] prev_fd = '0;
      logic [FB-1:0] fd_at   = '0;
      forever begin
         @(negedge CLK);
         if (RST) lowrun = -100;
         else if (s_ready === 1'b1) begin
            if (lowrun > 0) check("ready_low_len", lowrun, 2);
            lowrun = 0;
         end else lowrun++;
         if (prev_st != '0) begin
            check("strobe_width", FrameStrobe, 0);
            check("fd_after", FrameData, fd_at);
         end
         if (FrameStrobe != '0) begin
            check("strobe_onehot", $onehot(FrameStrobe), 1);
            check("strobe_delay", lowrun, 2);
            check("fd_before", FrameData, prev_fd);
            for (int i = 0; i < NS; i++) if (FrameStrobe[i]) obs_idx.push_back(i);
            obs_dat.push_back(FrameData);
            fd_at = FrameData;
         end
         prev_st = FrameStrobe;
         prev_fd = FrameData;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hdr;
      int          gap;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check("rst_ready", s_ready, 0);
      check("rst_fd", FrameData, 0);
      check("rst_strobe", FrameStrobe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      RST = 1'b0;
      @(negedge CLK);
      check("ready_after_rst", s_ready, 1);
      model_reset();

      // Back-to-back frame to column 2, frame 3
      put(SYNC, 0); put(32'h1000_0203, 0); put(32'h1111_1111, 0); put(32'h2222_2222, 0);
`ifdef FRAME_CHECK_EN
      put(32'h3333_3333, 0);
`endif
      settle();
      check("s1_idx", (obs_idx.size() > 0) ? obs_idx[0] : -1, 11);
      check("s1_fd", FrameData, 64'h2222_2222_1111_1111);
      compare_scn("s1");

      // Out-of-range column: error, then traffic ignored until resync
      put(32'h1000_0300, 0); put(32'h1000_0001, 0); put(32'h5555_5555, 0); put(32'h6666_6666, 0);
      settle();
      check("s2_err", err, 1);
      compare_scn("s2");

      // Desync then resync
      put(SYNC, 0); put(32'hF000_0000, 0);
      settle();
      check("s3_done", done, 1);
      check("s3_busy", busy, 0);
      put(SYNC, 1);
      settle();
      check("s3_done_clr", done, 0);
      compare_scn("s3");

      // Same frame with s_valid toggling
      put(32'h1000_0203, 1); put(32'h1111_1111, 1); put(32'h2222_2222, 1);
`ifdef FRAME_CHECK_EN
      put(32'h3333_3333, 1);
`endif
      settle();
      check("s4_idx", (obs_idx.size() > 0) ? obs_idx[0] : -1, 11);
      check("s4_fd", FrameData, 64'h2222_2222_1111_1111);
      compare_scn("s4");

`ifdef FRAME_CHECK_EN
      // Checksum mismatch drops the frame but stays synced
      do_reset();
      put(SYNC, 0); put(32'h1000_0203, 0); put(32'h1111_1111, 0); put(32'h2222_2222, 0);
      put(32'h3333_3334, 0);
      put(32'h1000_0001, 0); put(32'h0000_00A5, 0); put(32'h5A00_0000, 0); put(32'h5A00_00A5, 0);
      settle();
      check("s5_err", err, 1);
      check("s5_idx", (obs_idx.size() > 0) ? obs_idx[0] : -1, 1);
      compare_scn("s5");
`endif

      // Randomized stream
      do_reset();
      for (int n = 0; n < 160; n++) begin
         gap = $urandom_range(0, 2);
         case (m_mode)
            0: put(($urandom_range(0, 7) == 0) ? $urandom : SYNC, gap);
            1: begin
               hdr = $urandom & 32'h0FFF_0000;
               case ($urandom_range(0, 19))
                  0, 1:    hdr[31:28] = 4'hF;
                  2:       hdr[31:28] = 4'(($urandom_range(2, 14)));
                  default: hdr[31:28] = 4'h1;
               endcase
               hdr[15:8] = ($urandom_range(0, 9) == 0) ? 8'(NC)  : 8'($urandom_range(0, NC-1));
               hdr[7:0]  = ($urandom_range(0, 9) == 0) ? 8'(FPC) : 8'($urandom_range(0, FPC-1));
               put(hdr, gap);
            end
            2: put($urandom, gap);
            default: put(($urandom_range(0, 4) == 0) ? (m_x ^ 32'h0000_0100) : m_x, gap);
         endcase
      end
      settle();
      compare_scn("rnd");

      // Reset during the STROBE cycle
      do_reset();
      put(SYNC, 0); put(32'h1000_0203, 0); put(32'hAAAA_AAAA, 0); put(32'h5555_5555, 0);
`ifdef FRAME_CHECK_EN
      put(32'hFFFF_FFFF, 0);
`endif
      check("s7_ready_strobe", s_ready, 0);
      RST = 1'b1;
      @(negedge CLK);
      check("s7_strobe", FrameStrobe, 0);
      check("s7_fd", FrameData, 0);
      check("s7_ready", s_ready, 0);
      check("s7_busy", busy, 0);
      check("s7_done", done, 0);
      check("s7_err", err, 0);
      check("s7_nostrobe", obs_idx.size(), 0);
      RST = 1'b0;
      model_reset();
      @(negedge CLK);
      check("s7_strobe2", FrameStrobe, 0);
      check("s7_ready_up", s_ready, 1);
      put(32'h1000_0203, 0); put(32'h1234_5678, 0); put(32'h9ABC_DEF0, 0);
      settle();
      compare_scn("s7");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
